climate_level_controller: RTL and testbench

- Sits directly downstream of the configuration manager.
- Snapshots the four temperature limits and the humidity limit when configuration completes, and checks that they are consistent.
- Turns each valid sensor sample into a ventilation level (0..4) with hysteresis and N-sample confirmation, plus a humidity alert with hysteresis.
- Drives the actuator stage.

---
 rtl/climate_level_controller.sv | 179 +++++++++++++++++
 tb/tb_climate_level_controller.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/climate_level_controller.sv
// Ventilation level controller: snapshots the configuration limits, then maps
// sensor samples to a confirmed level (0..4) and a humidity alert with hysteresis.
module climate_level_controller #(
  parameter logic [15:0] HIST       = 16'd20,
  parameter logic [15:0] HIST_UM    = 16'd50,
  parameter int          N_CONFIRMA = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pronto_config,
  input  logic [15:0] temp_lim1_in,
  input  logic [15:0] temp_lim2_in,
  input  logic [15:0] temp_lim3_in,
  input  logic [15:0] temp_lim4_in,
  input  logic [15:0] umidade_lim_in,
  input  logic        medida_valida,
  input  logic [15:0] temperatura,
  input  logic [15:0] umidade,
  output logic [2:0]  nivel,
  output logic        alerta_umidade,
  output logic        erro_limites,
  output logic [2:0]  db_estado
);

  localparam logic [2:0] ESPERA_CONFIG = 3'd0;
  localparam logic [2:0] CARREGA       = 3'd1;
  localparam logic [2:0] OCIOSO        = 3'd2;
  localparam logic [2:0] AVALIA        = 3'd3;
  localparam logic [2:0] APLICA        = 3'd4;

  localparam logic [3:0] N_CFG = 4'(N_CONFIRMA);

  logic [2:0]  state_q, state_d;
  logic        pronto_q;
  logic [15:0] lim_q [4];
  logic [15:0] lim_d [4];
  logic [15:0] umid_lim_q, umid_lim_d;
  logic [15:0] temp_q, temp_d;
  logic [15:0] umid_q, umid_d;
  logic [2:0]  nivel_q, nivel_d;
  logic [2:0]  cand_q, cand_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        alerta_q, alerta_d;
  logic        erro_q, erro_d;

  logic        cfg_rise;
  logic        lims_ok;
  logic [16:0] temp_hist;
  logic [16:0] umid_hist;
  logic [2:0]  raw_lvl, down_lvl, cand_lvl;
  logic [3:0]  cnt_inc;

  assign cfg_rise  = pronto_config & ~pronto_q;
  assign lims_ok   = (temp_lim1_in < temp_lim2_in) && (temp_lim2_in < temp_lim3_in) &&
                     (temp_lim3_in < temp_lim4_in);
  assign temp_hist = {1'b0, temp_q} + {1'b0, HIST};
  assign umid_hist = {1'b0, umid_q} + {1'b0, HIST_UM};

  // Step up on raw thresholds, step down only once the hysteresis band is cleared.
  always_comb begin
    raw_lvl  = 3'd0;
    down_lvl = 3'd0;
    for (int k = 0; k < 4; k++) begin
      raw_lvl  = raw_lvl  + {2'b00, (temp_q >= lim_q[k])};
      down_lvl = down_lvl + {2'b00, (temp_hist >= {1'b0, lim_q[k]})};
    end
    if (raw_lvl > nivel_q)
      cand_lvl = raw_lvl;
    else if (down_lvl < nivel_q)
      cand_lvl = down_lvl;
    else
      cand_lvl = nivel_q;
  end

  assign cnt_inc = (cnt_q >= N_CFG) ? N_CFG : cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    lim_d      = lim_q;
    umid_lim_d = umid_lim_q;
    temp_d     = temp_q;
    umid_d     = umid_q;
    nivel_d    = nivel_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    alerta_d   = alerta_q;
    erro_d     = erro_q;

    if (cfg_rise && state_q != CARREGA) begin
      state_d = CARREGA;
    end else begin
      case (state_q)
        CARREGA: begin
          lim_d[0]   = temp_lim1_in;
          lim_d[1]   = temp_lim2_in;
          lim_d[2]   = temp_lim3_in;
          lim_d[3]   = temp_lim4_in;
          umid_lim_d = umidade_lim_in;
          if (lims_ok) begin
            erro_d  = 1'b0;
            cnt_d   = 4'd0;
            state_d = OCIOSO;
          end else begin
            erro_d   = 1'b1;
            nivel_d  = 3'd0;
            alerta_d = 1'b0;
            state_d  = ESPERA_CONFIG;
          end
        end
        OCIOSO: begin
          if (medida_valida) begin
            temp_d  = temperatura;
            umid_d  = umidade;
            state_d = AVALIA;
          end
        end
        AVALIA: begin
          if (umid_q > umid_lim_q)
            alerta_d = 1'b1;
          else if (umid_hist <= {1'b0, umid_lim_q})
            alerta_d = 1'b0;

          state_d = OCIOSO;
          if (cand_lvl == nivel_q) begin
            cnt_d = 4'd0;
          end else if (cand_lvl == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == N_CFG) state_d = APLICA;
          end else begin
            cand_d = cand_lvl;
            cnt_d  = 4'd1;
            if (N_CFG == 4'd1) state_d = APLICA;
          end
        end
        APLICA: begin
          nivel_d = cand_q;
          cnt_d   = 4'd0;
          state_d = OCIOSO;
        end
        ESPERA_CONFIG: ;
        default: state_d = ESPERA_CONFIG;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ESPERA_CONFIG;
      pronto_q   <= 1'b0;
      for (int k = 0; k < 4; k++) lim_q[k] <= 16'd0;
      umid_lim_q <= 16'd0;
      temp_q     <= 16'd0;
      umid_q     <= 16'd0;
      nivel_q    <= 3'd0;
      cand_q     <= 3'd0;
      cnt_q      <= 4'd0;
      alerta_q   <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pronto_q   <= pronto_config;
      lim_q      <= lim_d;
      umid_lim_q <= umid_lim_d;
      temp_q     <= temp_d;
      umid_q     <= umid_d;
      nivel_q    <= nivel_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      alerta_q   <= alerta_d;
      erro_q     <= erro_d;
    end
  end

  assign nivel          = nivel_q;
  assign alerta_umidade = alerta_q;
  assign erro_limites   = erro_q;
  assign db_estado      = state_q;

endmodule

// File: tb/tb_climate_level_controller.sv
// Self-checking bench: directed scenarios plus randomized samples against a
// threshold-counting reference model.
module tb_climate_level_controller;

  localparam int HIST = 20;
  localparam int HIST_UM = 50;
  localparam int NCONF = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pronto_config = 1'b0;
  logic [15:0] temp_lim1_in = '0, temp_lim2_in = '0, temp_lim3_in = '0, temp_lim4_in = '0;
  logic [15:0] umidade_lim_in = '0;
  logic        medida_valida = 1'b0;
  logic [15:0] temperatura = '0, umidade = '0;
  logic [2:0]  nivel;
  logic        alerta_umidade;
  logic        erro_limites;
  logic [2:0]  db_estado;

  int total = 0;
  int bad = 0;

  // reference model state
  int m_lim [4];
  int m_ulim;
  int m_nivel, m_alert, m_erro, m_cand, m_run;

  climate_level_controller dut (
    .clock(clock), .reset(reset), .pronto_config(pronto_config),
    .temp_lim1_in(temp_lim1_in), .temp_lim2_in(temp_lim2_in),
    .temp_lim3_in(temp_lim3_in), .temp_lim4_in(temp_lim4_in),
    .umidade_lim_in(umidade_lim_in), .medida_valida(medida_valida),
    .temperatura(temperatura), .umidade(umidade), .nivel(nivel),
    .alerta_umidade(alerta_umidade), .erro_limites(erro_limites), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_lim[k] = 0;
    m_ulim = 0; m_nivel = 0; m_alert = 0; m_erro = 0; m_cand = 0; m_run = 0;
  endtask

  // One sample: level = count of thresholds reached, with hysteresis on the way down,
  // applied only after NCONF consecutive identical proposals.
  task automatic model_sample(input int t, input int u);
    int up, dn, want;
    up = 0; dn = 0;
    for (int k = 0; k < 4; k++) begin
      if (t >= m_lim[k]) up++;
      if (t + HIST >= m_lim[k]) dn++;
    end
    want = (up > m_nivel) ? up : ((dn < m_nivel) ? dn : m_nivel);
    if (want == m_nivel) m_run = 0;
    else begin
      if (want == m_cand) m_run = (m_run >= NCONF) ? NCONF : m_run + 1;
      else begin m_cand = want; m_run = 1; end
      if (m_run == NCONF) begin m_nivel = m_cand; m_run = 0; end
    end
    if (u > m_ulim) m_alert = 1;
    else if (u + HIST_UM <= m_ulim) m_alert = 0;
  endtask

  task automatic set_limits(input int l1, input int l2, input int l3, input int l4, input int ul);
    temp_lim1_in = 16'(l1); temp_lim2_in = 16'(l2);
    temp_lim3_in = 16'(l3); temp_lim4_in = 16'(l4);
    umidade_lim_in = 16'(ul);
  endtask

  task automatic model_config(input int l1, input int l2, input int l3, input int l4, input int ul);
    m_lim[0] = l1; m_lim[1] = l2; m_lim[2] = l3; m_lim[3] = l4; m_ulim = ul;
    if (l1 < l2 && l2 < l3 && l3 < l4) begin
      m_erro = 0; m_run = 0;
    end else begin
      m_erro = 1; m_nivel = 0; m_alert = 0;
    end
  endtask

  task automatic check_outputs(input string name, input int exp_state);
    total++;
    if (nivel !== 3'(m_nivel) || alerta_umidade !== 1'(m_alert) ||
        erro_limites !== 1'(m_erro) || db_estado !== 3'(exp_state)) begin
      bad++;
      $display("FAIL %s: nivel=%0d alerta=%0d erro=%0d estado=%0d required nivel=%0d alerta=%0d erro=%0d estado=%0d",
               name, nivel, alerta_umidade, erro_limites, db_estado,
               m_nivel, m_alert, m_erro, exp_state);
    end
  endtask

  task automatic do_config(input string name, input int l1, input int l2, input int l3,
                           input int l4, input int ul);
    set_limits(l1, l2, l3, l4, ul);
    pronto_config = 1'b1;
    tick();
    total++;
    if (db_estado !== 3'd1) begin
      bad++;
      $display("FAIL %s_carrega: estado=%0d required 1", name, db_estado);
    end
    tick();
    model_config(l1, l2, l3, l4, ul);
    check_outputs(name, m_erro ? 0 : 2);
    $display("config %s: lims=%0d/%0d/%0d/%0d ulim=%0d erro=%0d", name, l1, l2, l3, l4, ul, erro_limites);
    pronto_config = 1'b0;
    tick();
  endtask

  // Strobe, then wait until a possible level update has landed (edge k+2).
  task automatic do_sample(input string name, input int t, input int u);
    temperatura = 16'(t); umidade = 16'(u);
    medida_valida = 1'b1;
    tick();
    medida_valida = 1'b0;
    tick();
    tick();
    model_sample(t, u);
    check_outputs(name, 2);
    $display("sample %s: temp=%0d umid=%0d nivel=%0d alerta=%0d", name, t, u, nivel, alerta_umidade);
  endtask

  task automatic test_reset();
    model_reset();
    reset = 1'b1;
    tick(); tick();
    check_outputs("reset", 0);
    reset = 1'b0;
    tick();
    check_outputs("reset_release", 0);
  endtask

  task automatic test_config_valid();
    do_config("cfg_valid", 250, 300, 350, 400, 600);
  endtask

  task automatic test_confirmation();
    do_sample("conf_a1", 320, 500);
    do_sample("conf_a2", 320, 500);
    do_sample("conf_a3_260", 260, 500);
    do_sample("conf_b1", 320, 500);
    do_sample("conf_b2", 320, 500);
    // third strobe watched edge by edge for the exact latency
    temperatura = 16'd320; umidade = 16'd500;
    medida_valida = 1'b1;
    tick();
    medida_valida = 1'b0;
    tick();
    total++;
    if (nivel !== 3'd0) begin
      bad++;
      $display("FAIL latency_k1: nivel=%0d required 0", nivel);
    end
    tick();
    model_sample(320, 500);
    total++;
    if (nivel !== 3'd2 || m_nivel != 2) begin
      bad++;
      $display("FAIL latency_k2: nivel=%0d model=%0d required 2", nivel, m_nivel);
    end
    $display("sample conf_b3: temp=320 nivel=%0d", nivel);
  endtask

  task automatic test_hysteresis();
    for (int i = 0; i < 3; i++) do_sample("hyst_295", 295, 500);
    total++;
    if (nivel !== 3'd2) begin bad++; $display("FAIL hyst_hold: nivel=%0d required 2", nivel); end
    for (int i = 0; i < 3; i++) do_sample("hyst_279", 279, 500);
    total++;
    if (nivel !== 3'd1) begin bad++; $display("FAIL hyst_down: nivel=%0d required 1", nivel); end
  endtask

  task automatic test_humidity();
    do_sample("hum_601", 279, 601);
    total++;
    if (alerta_umidade !== 1'b1) begin bad++; $display("FAIL hum_set: alerta=%0d required 1", alerta_umidade); end
    do_sample("hum_560", 279, 560);
    total++;
    if (alerta_umidade !== 1'b1) begin bad++; $display("FAIL hum_hold: alerta=%0d required 1", alerta_umidade); end
    do_sample("hum_550", 279, 550);
    total++;
    if (alerta_umidade !== 1'b0) begin bad++; $display("FAIL hum_clear: alerta=%0d required 0", alerta_umidade); end
  endtask

  task automatic test_invalid_config();
    do_sample("pre_inv_alert", 279, 700);
    do_config("cfg_invalid", 250, 300, 300, 400, 600);
    total++;
    if (erro_limites !== 1'b1 || nivel !== 3'd0 || alerta_umidade !== 1'b0) begin
      bad++;
      $display("FAIL invalid_cfg: erro=%0d nivel=%0d alerta=%0d required 1/0/0",
               erro_limites, nivel, alerta_umidade);
    end
    for (int i = 0; i < 3; i++) begin
      temperatura = 16'd500; umidade = 16'd900;
      medida_valida = 1'b1;
      tick();
      medida_valida = 1'b0;
      tick(); tick();
      check_outputs("espera_ignore", 0);
    end
    do_config("cfg_reload", 250, 300, 350, 400, 600);
  endtask

  task automatic test_cfg_strobe_collision();
    set_limits(100, 200, 300, 400, 600);
    pronto_config = 1'b1;
    temperatura = 16'd500; umidade = 16'd900;
    medida_valida = 1'b1;
    tick();
    medida_valida = 1'b0;
    total++;
    if (db_estado !== 3'd1) begin bad++; $display("FAIL collide_carrega: estado=%0d required 1", db_estado); end
    tick();
    model_config(100, 200, 300, 400, 600);
    check_outputs("collide_dropped", 2);
    pronto_config = 1'b0;
    tick();
    check_outputs("collide_idle", 2);
    for (int i = 0; i < 3; i++) do_sample("collide_relatch", 150, 500);
    total++;
    if (nivel !== 3'd1) begin bad++; $display("FAIL collide_newlims: nivel=%0d required 1", nivel); end
  endtask

  task automatic test_random();
    int l1, l2, l3, l4, ul, t, u, k, reps;
    for (int c = 0; c < 3; c++) begin
      l1 = $urandom_range(100, 1000);
      l2 = l1 + $urandom_range(1, 100);
      l3 = l2 + $urandom_range(1, 100);
      l4 = l3 + $urandom_range(1, 100);
      ul = $urandom_range(200, 800);
      do_config("cfg_rand", l1, l2, l3, l4, ul);
      for (int s = 0; s < 25; s++) begin
        k = $urandom_range(0, 3);
        t = m_lim[k] + $urandom_range(0, 80) - 40;
        u = ul + $urandom_range(0, 140) - 80;
        reps = $urandom_range(1, 4);
        for (int r = 0; r < reps; r++) do_sample("rand", t, u);
      end
    end
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 3; i++) do_sample("jump_to_4", m_lim[3] + 10, m_ulim + 5);
    total++;
    if (nivel !== 3'd4 || alerta_umidade !== 1'b1) begin
      bad++;
      $display("FAIL jump4: nivel=%0d alerta=%0d required 4/1", nivel, alerta_umidade);
    end
    temperatura = 16'd0; umidade = 16'd0;
    medida_valida = 1'b1;
    tick();
    medida_valida = 1'b0;
    total++;
    if (db_estado !== 3'd3) begin bad++; $display("FAIL midop_avalia: estado=%0d required 3", db_estado); end
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("reset_midop", 0);
    tick();
    reset = 1'b0;
    tick();
    check_outputs("reset_midop_after", 0);
  endtask

  initial begin
    test_reset();
    test_config_valid();
    test_confirmation();
    test_hysteresis();
    test_humidity();
    test_invalid_config();
    test_cfg_strobe_collision();
    test_random();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
